fill_memory_fsm: RTL and testbench

//  Initialises a 256x8 on-chip RAM (RC4 S-array) to the identity permutation: S[i] = i for i = 0..255.

---
 rtl/fill_memory_fsm.sv | 92 +++++++++
 tb/tb_fill_memory_fsm.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fill_memory_fsm.sv
// Fills a 2**ADDR_WIDTH x ADDR_WIDTH RAM with the identity permutation (RC4 S-array init).
// Pulse start; 256 consecutive writes follow, then finish is held until the next start.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | post-reset, waiting for start; no writes, finish low
// WRITE | one write per cycle, address = data = counter
// DONE  | fill complete; finish high, address/data hold the last index
module fill_memory_fsm #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  is_write,
  output logic [ADDR_WIDTH-1:0] address_out,
  output logic [ADDR_WIDTH-1:0] data_out,
  output logic                  finish
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  is_write_d, finish_d;
  logic [ADDR_WIDTH-1:0] address_d;

  // Outputs are flopped from the next-state decode so the RAM sees glitch-free
  // write enable/address/data for a full cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_write    <= 1'b0;
      finish      <= 1'b0;
      address_out <= '0;
      data_out    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_write    <= is_write_d;
      finish      <= finish_d;
      address_out <= address_d;
      data_out    <= address_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          cnt_d   = '0;
        end
      end
      WRITE: begin
        // Terminal compare on all-ones; the counter parks at the last index
        // instead of wrapping into a 257th write.
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_d = WRITE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    is_write_d = (state_d == WRITE);
    finish_d   = (state_d == DONE);
    address_d  = cnt_d;
  end

endmodule

// File: tb/tb_fill_memory_fsm.sv
// Scoreboard bench for fill_memory_fsm: stimulus pushes the expected write stream,
// a negedge monitor pops and compares, and a RAM model is checked at finish.
module tb_fill_memory_fsm;

  localparam int AW = 8;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          is_write;
  logic [AW-1:0] address_out;
  logic [AW-1:0] data_out;
  logic          finish;

  fill_memory_fsm #(.ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_write    (is_write),
    .address_out (address_out),
    .data_out    (data_out),
    .finish      (finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    int when;
    int addr;
    bit fin;
  } exp_t;

  exp_t     exp_q[$];
  logic [8:0] mem [N];
  int       vectors = 0;
  int       miscompares = 0;
  int       ncyc = 0;
  int       last_c = 0;
  bit       model_fin = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard slot per negedge.
  always @(negedge clk) begin
    exp_t e;
    int   bad;
    if (exp_q.size() > 0 && exp_q[0].when == ncyc) begin
      e = exp_q.pop_front();
      if (e.fin) begin
        check("finish_rise", int'(finish), 1);
        check("no_write_at_finish", int'(is_write), 0);
        bad = -1;
        for (int i = 0; i < N; i++)
          if (mem[i] !== 9'(i) && bad < 0) bad = i;
        check("ram_identity_first_bad_index", bad, -1);
        model_fin = 1'b1;
      end else begin
        check("write_enable", int'(is_write), 1);
        check("write_address", int'(address_out), e.addr);
        check("write_data", int'(data_out), e.addr);
        check("finish_low_while_writing", int'(finish), 0);
        model_fin = 1'b0;
      end
    end else begin
      check("no_unexpected_write", int'(is_write), 0);
      check("finish_level", int'(finish), int'(model_fin));
    end
    if (is_write) mem[address_out] = {1'b0, data_out};
    ncyc++;
  end

  task automatic pulse_start(input int width);
    exp_t e;
    @(negedge clk); #1;
    last_c = ncyc;
    start  = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = 9'h1ff;
    for (int i = 0; i < N; i++) begin
      e.when = last_c + i; e.addr = i; e.fin = 1'b0;
      exp_q.push_back(e);
    end
    e.when = last_c + N; e.addr = 0; e.fin = 1'b1;
    exp_q.push_back(e);
    repeat (width) begin @(negedge clk); #1; end
    start = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (exp_q.size() > 0 && g < 400) begin @(negedge clk); g++; end
    #1;
    check("fill_completed_in_time", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_addr(input int a);
    int g = 0;
    while (ncyc <= last_c + a && g < 400) begin @(negedge clk); g++; end
    #1;
  endtask

  // Assert reset between edges and check outputs clear without a clock edge.
  task automatic async_reset(input int hold);
    rst_n = 1'b0;
    #1;
    check("rst_is_write", int'(is_write), 0);
    check("rst_finish", int'(finish), 0);
    check("rst_address", int'(address_out), 0);
    check("rst_data", int'(data_out), 0);
    exp_q.delete();
    model_fin = 1'b0;
    repeat (hold) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  initial begin
    #3;
    check("por_is_write", int'(is_write), 0);
    check("por_finish", int'(finish), 0);
    check("por_address", int'(address_out), 0);
    check("por_data", int'(data_out), 0);
    idle(2);
    rst_n = 1'b1;

    idle(20);

    pulse_start(1);
    wait_done();
    idle(10);

    async_reset(2);
    idle(3);

    pulse_start($urandom_range(1, 4));
    wait_done();
    idle($urandom_range(2, 12));
    pulse_start(1);
    wait_done();

    pulse_start(1);
    wait_addr(100);
    async_reset(2);
    idle(2);
    pulse_start(1);
    wait_done();

    for (int r = 0; r < 4; r++) begin
      pulse_start($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1) begin
        wait_addr($urandom_range(1, N - 2));
        async_reset($urandom_range(1, 3));
        idle($urandom_range(1, 5));
      end else begin
        wait_done();
        idle($urandom_range(0, 6));
      end
    end

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
